// File: rtl/shift_sequencer.sv
// Multi-cycle 16-bit shift/rotate unit: walks the 8/4/2/1 stage distances one per clock,
// reusing a single stage slice instead of a full barrel shifter.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic [1:0]       Op,
  input  logic             Ack,
  output logic             Ready,
  output logic             Valid,
  output logic [WIDTH-1:0] Out
);

  localparam int IDX_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_t;

  state_t           state, state_next;
  op_t              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] stage_out [CNT_W];
  logic [WIDTH-1:0] acc_step;

  // Every stage distance is a constant after unrolling; idx only picks which slice result to use.
  always_comb begin
    for (int s = 0; s < CNT_W; s++) begin
      case (op_q)
        OP_ROL:  stage_out[s] = (acc << (1 << s)) | (acc >> (WIDTH - (1 << s)));
        OP_SLL:  stage_out[s] = acc << (1 << s);
        OP_ROR:  stage_out[s] = (acc >> (1 << s)) | (acc << (WIDTH - (1 << s)));
        default: stage_out[s] = acc >> (1 << s);
      endcase
    end
  end

  assign acc_step = cnt_q[idx] ? stage_out[idx] : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    state_next = state;
    Ready      = 1'b0;
    Valid      = 1'b0;
    case (state)
      IDLE: begin
        Ready = 1'b1;
        if (Start) state_next = SHIFT;
      end
      SHIFT: begin
        if (idx == '0) state_next = DONE;
      end
      DONE: begin
        Valid = 1'b1;
        if (Ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt_q <= '0;
      op_q  <= OP_ROL;
      idx   <= IDX_W'(CNT_W - 1);
      Out   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the order.
      case (state)
        IDLE: begin
          if (Start) begin
            acc   <= In;
            cnt_q <= Cnt;
            op_q  <= op_t'(Op);
            idx   <= IDX_W'(CNT_W - 1);
          end
        end
        SHIFT: begin
          acc <= acc_step;
          if (idx == '0) begin
            Out <= acc_step;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  a_ready_valid_exclusive: assert property (
    @(posedge clk) disable iff (rst) !(Ready && Valid));

  a_done_holds: assert property (
    @(posedge clk) disable iff (rst)
    (state == DONE && !Ack) |=> (state == DONE && $stable(Out)));

endmodule
